// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared state type, reset configuration and legality check for clkdiv_scheduler
package clkdiv_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
    localparam int DIV_RST = 4;
    localparam int HIGH_RST = 2;
    function automatic logic cfg_legal(input int unsigned div, input int unsigned high);
        return div >= 2 && high >= 1 && high < div;
    endfunction
endpackage

// File: rtl/clkdiv_counter.sv
// clkdiv_counter: period counter with wrap and high-time compares
module clkdiv_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic [CNT_W-1:0] div,
    input  logic [CNT_W-1:0] high,
    output logic             wrap,
    output logic             below_high
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        wrap = active && cnt_q == div - CNT_W'(1);
        cnt_d = (!active || wrap) ? '0 : cnt_q + CNT_W'(1);
        below_high = ({1'b0, cnt_q} + (CNT_W+1)'(1)) < {1'b0, high};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/clkdiv_scheduler.sv
// clkdiv_scheduler: programmable clock divider with shadowed reconfiguration; CLKDIV_PERIOD_CNT_EN adds period_cnt
module clkdiv_scheduler
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clockin,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clockout,
    output logic             tick,
`ifdef CLKDIV_PERIOD_CNT_EN
    output logic [15:0]      period_cnt,
`endif
    output logic             busy
);
    state_t state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d, high_q, high_d, sdiv_q, sdiv_d, shigh_q, shigh_d;
    logic clockout_q, clockout_d, tick_q, tick_d, err_q, err_d;
    logic idle, load, apply, wrap, below_high;
    clkdiv_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clockin),
        .rst_n     (reset),
        .active    (!idle),
        .div       (div_q),
        .high      (high_q),
        .wrap      (wrap),
        .below_high(below_high)
    );
    assign cfg_ready = state_q != PEND;
    assign busy = state_q != IDLE;
    assign cfg_err = err_q;
    assign clockout = clockout_q;
    assign tick = tick_q;
    always_comb begin
        idle = state_q == IDLE;
        load = cfg_valid && cfg_ready && cfg_legal(32'(cfg_div), 32'(cfg_high));
        apply = wrap && state_q == PEND;
        err_d = cfg_valid && cfg_ready && !cfg_legal(32'(cfg_div), 32'(cfg_high));
        div_d = idle && load ? cfg_div : apply ? sdiv_q : div_q;
        high_d = idle && load ? cfg_high : apply ? shigh_q : high_q;
        sdiv_d = !idle && load ? cfg_div : sdiv_q;
        shigh_d = !idle && load ? cfg_high : shigh_q;
        state_d = idle ? (run ? RUN : IDLE)
                : wrap ? (!run ? IDLE : load ? PEND : RUN)
                : load ? PEND : state_q;
        clockout_d = (idle || wrap) ? run : below_high;
        tick_d = (idle || wrap) && run;
    end
    always_ff @(posedge clockin or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q <= CNT_W'(DIV_RST);
            high_q <= CNT_W'(HIGH_RST);
            sdiv_q <= '0;
            shigh_q <= '0;
            clockout_q <= 1'b0;
            tick_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q <= div_d;
            high_q <= high_d;
            sdiv_q <= sdiv_d;
            shigh_q <= shigh_d;
            clockout_q <= clockout_d;
            tick_q <= tick_d;
            err_q <= err_d;
        end
    end
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] period_cnt_q, period_cnt_d;
    assign period_cnt = period_cnt_q;
    always_comb period_cnt_d = idle && run ? 16'd0 : wrap && run ? period_cnt_q + 16'd1 : period_cnt_q;
    always_ff @(posedge clockin or negedge reset) begin
        if (!reset) period_cnt_q <= '0;
        else period_cnt_q <= period_cnt_d;
    end
`endif
endmodule

// File: tb/tb_clkdiv_scheduler.sv
// tb_clkdiv_scheduler: directed vectors with a scoreboard queue checked by an independent monitor
module tb_clkdiv_scheduler;
    logic clockin = 1'b0, reset = 1'b0, run = 1'b0, cfg_valid = 1'b0;
    logic [7:0] cfg_div = '0, cfg_high = '0;
    logic cfg_ready, cfg_err, clockout, tick, busy;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif
    typedef struct {logic [4:0] exp; int n;} item_t;
    item_t q[$];
    int checks = 0, errors = 0, ncyc = 0;
    clkdiv_scheduler #(.CNT_W(8)) dut (
        .clockin  (clockin),
        .reset    (reset),
        .run      (run),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .cfg_ready(cfg_ready),
        .cfg_err  (cfg_err),
        .clockout (clockout),
        .tick     (tick),
`ifdef CLKDIV_PERIOD_CNT_EN
        .period_cnt(period_cnt),
`endif
        .busy     (busy)
    );
    always #5 clockin = ~clockin;
    task automatic cyc(input logic rn, input logic r, input logic v, input logic [7:0] d, input logic [7:0] h,
                       input logic [4:0] e);
        item_t it;
        @(negedge clockin);
        reset = rn;
        run = r;
        cfg_valid = v;
        cfg_div = d;
        cfg_high = h;
        ncyc++;
        it.exp = e;
        it.n = ncyc;
        q.push_back(it);
    endtask
    initial begin
        item_t it;
        logic [4:0] got;
        forever begin
            @(posedge clockin);
            #1;
            if (q.size() > 0) begin
                it = q.pop_front();
                got = {clockout, tick, busy, cfg_ready, cfg_err};
                checks++;
                if (got !== it.exp) begin
                    errors++;
                    $display("FAIL cycle%0d {clockout,tick,busy,cfg_ready,cfg_err} got %b expected %b", it.n, got, it.exp);
                end
            end
        end
    end
    initial begin
        repeat (2) cyc(0, 0, 0, 0, 0, 5'b00010);
        #1;
        checks++;
        if ({clockout, tick, busy, cfg_ready, cfg_err} !== 5'b00010) begin
            errors++;
            $display("FAIL reset state got %b expected 00010", {clockout, tick, busy, cfg_ready, cfg_err});
        end
        cyc(1, 1, 0, 0, 0, 5'b11110);
        cyc(1, 1, 0, 0, 0, 5'b10110);
        repeat (2) cyc(1, 1, 0, 0, 0, 5'b00110);
        cyc(1, 1, 0, 0, 0, 5'b11110);
        cyc(1, 1, 0, 0, 0, 5'b10110);
        repeat (2) cyc(1, 1, 0, 0, 0, 5'b00110);
        cyc(1, 1, 1, 3, 3, 5'b11111);
        cyc(1, 1, 0, 0, 0, 5'b10110);
        cyc(1, 1, 1, 6, 3, 5'b00100);
        cyc(1, 1, 1, 3, 3, 5'b00100);
        cyc(1, 1, 0, 0, 0, 5'b11110);
        repeat (2) cyc(1, 1, 0, 0, 0, 5'b10110);
        repeat (3) cyc(1, 1, 0, 0, 0, 5'b00110);
        cyc(1, 1, 0, 0, 0, 5'b11110);
        repeat (2) cyc(1, 1, 0, 0, 0, 5'b10110);
        repeat (3) cyc(1, 1, 0, 0, 0, 5'b00110);
        repeat (2) cyc(1, 0, 0, 0, 0, 5'b00010);
        cyc(1, 0, 1, 5, 1, 5'b00010);
        cyc(1, 1, 0, 0, 0, 5'b11110);
        repeat (4) cyc(1, 1, 0, 0, 0, 5'b00110);
        cyc(1, 1, 0, 0, 0, 5'b11110);
        repeat (4) cyc(1, 1, 0, 0, 0, 5'b00110);
        cyc(1, 1, 0, 0, 0, 5'b11110);
        cyc(1, 1, 1, 4, 2, 5'b00100);
        repeat (3) cyc(1, 1, 0, 0, 0, 5'b00100);
        cyc(1, 1, 0, 0, 0, 5'b11110);
        cyc(1, 1, 0, 0, 0, 5'b10110);
        repeat (2) cyc(1, 1, 0, 0, 0, 5'b00110);
        cyc(1, 1, 0, 0, 0, 5'b11110);
        cyc(1, 0, 0, 0, 0, 5'b10110);
        repeat (2) cyc(1, 0, 0, 0, 0, 5'b00110);
        repeat (2) cyc(1, 0, 0, 0, 0, 5'b00010);
        cyc(1, 1, 0, 0, 0, 5'b11110);
        cyc(1, 1, 1, 6, 3, 5'b10100);
        cyc(1, 1, 0, 0, 0, 5'b00100);
        repeat (2) cyc(0, 1, 0, 0, 0, 5'b00010);
        cyc(1, 1, 0, 0, 0, 5'b11110);
        cyc(1, 1, 0, 0, 0, 5'b10110);
        repeat (2) cyc(1, 1, 0, 0, 0, 5'b00110);
        cyc(1, 1, 0, 0, 0, 5'b11110);
        cyc(1, 1, 0, 0, 0, 5'b10110);
        repeat (3) @(posedge clockin);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL wait expired with %0d unchecked expectations", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clkdiv_scheduler.md
CLKDIV_SCHEDULER -- requirements
Module: clkdiv_scheduler

Interface
REQ-001 Parameter CNT_W, default 8: width of the divide-ratio and high-time fields.
REQ-002 clockin  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
REQ-004 run  input  1  level request to generate the divided clock.
REQ-005 cfg_valid  input  1  new configuration offered.
REQ-006 cfg_div  input  CNT_W  requested period in clockin cycles.
REQ-007 cfg_high  input  CNT_W  requested high time in clockin cycles.
REQ-008 cfg_ready  output  1  configuration can be accepted this cycle.
REQ-009 cfg_err  output  1  one-cycle pulse when an accepted configuration was illegal and discarded.
REQ-010 clockout  output  1  registered divided clock.
REQ-011 tick  output  1  one-cycle pulse in the first cycle of every clockout period.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL use states IDLE, RUN and PEND (RUN with a shadow configuration waiting).
REQ-014 A configuration is legal iff cfg_div >= 2 and 1 <= cfg_high <= cfg_div-1.
REQ-015 Transfer occurs when cfg_valid and cfg_ready are both high at a rising edge; cfg_ready SHALL be 1 in IDLE and RUN and 0 in PEND.
REQ-016 An illegal transfer SHALL be discarded with cfg_err high for the following cycle; the state is unchanged.
REQ-017 A legal transfer in IDLE SHALL load the active div/high registers at that edge.
REQ-018 A legal transfer in RUN SHALL load a shadow register and enter PEND; it is applied at the next period boundary, excluding any boundary at that same edge.
REQ-019 Period boundary: an edge where the state is RUN/PEND and cnt == div-1.
REQ-020 IDLE -> RUN at an edge where run=1; at that edge cnt<=0, clockout<=1, tick<=1.
REQ-021 In RUN/PEND at a non-boundary edge: cnt<=cnt+1, clockout<=(cnt+1 < high), tick<=0.
REQ-022 At a boundary with run=1: cnt<=0, clockout<=1, tick<=1; in PEND the shadow becomes active and the state returns to RUN.
REQ-023 At a boundary with run=0: state<=IDLE, cnt<=0, clockout<=0, tick<=0; a pending shadow is still applied.
REQ-024 Deasserting run mid-period SHALL NOT truncate the period; the stop takes effect only at the boundary.
REQ-025 In IDLE, clockout, tick and cnt SHALL hold 0.

Reset
REQ-026 Reset SHALL force state IDLE, cnt 0, clockout 0, tick 0, cfg_err 0, shadow cleared, active div=4, high=2 (divide-by-4, 50% duty).
REQ-027 Reset asserted mid-period SHALL discard the period and any pending configuration without a glitch beyond the asynchronous clear.

Configuration
REQ-028 Macro CLKDIV_PERIOD_CNT_EN defined: adds output period_cnt [15:0], incremented at every boundary with run=1, wrapping 0xFFFF->0, cleared on IDLE->RUN and by reset.
REQ-029 Macro undefined: period_cnt port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package clkdiv_pkg SHALL hold the state typedef, DIV_RST=4, HIGH_RST=2 and the legality check function.
REQ-031 Sub-module clkdiv_counter (cnt register, wrap compare, high compare) SHALL be instantiated once; the FSM and handshake stay in the top level.

Verification
REQ-032 After reset, run=1 -> clockout 1,1,0,0 repeating; tick every 4th cycle; busy=1.
REQ-033 In IDLE, transfer div=5/high=1, then run=1 -> clockout 1,0,0,0,0 repeating.
REQ-034 Running div=4, transfer div=6/high=3 at cnt=1 -> PEND, cfg_ready=0; current period completes at 4 cycles, then 1,1,1,0,0,0.
REQ-035 Transfer div=3/high=3 -> cfg_err one cycle, configuration and waveform unchanged.
REQ-036 run dropped at cnt=0 of a div=4 period -> three more cycles of the period, then IDLE, clockout 0, busy 0.
REQ-037 reset asserted at cnt=2 with a pending configuration -> immediate IDLE; next run uses div=4/high=2.
